// File: rtl/robs_pkg.sv
// Shared definitions for the sequential Robertson's multiplier.
//   robs_state_t : controller states (IDLE, CALC, DONE)
//   robs_cw()    : iteration counter width for a given operand width
package robs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } robs_state_t;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int robs_cw(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/robs_mult_ctrl.sv
// Controller for robs_mult_seq: state machine and iteration counter.
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   in_valid       : operation offered by the producer
//   op_zero        : one of the offered operands is zero (early exit)
//   abort          : cancel an operation in CALC
//   out_ready      : consumer takes the product
//   in_ready       : state == IDLE
//   out_valid      : state == DONE
//   busy           : state == CALC
//   load           : accept strobe, datapath latches operands
//   step           : one add/shift iteration this cycle
//   last_step      : current iteration is the final (sign-weighted) one
module robs_mult_ctrl
  import robs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = robs_cw(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic op_zero,
  input  logic abort,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic busy,
  output logic load,
  output logic step,
  output logic last_step
);

  robs_state_t   state_q;
  logic [CW-1:0] cnt_q;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign load      = in_ready & in_valid;
  // abort takes priority over the iteration, including the final one
  assign step      = busy & ~abort;
  assign last_step = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q   <= CW'(WIDTH - 1);
            state_q <= op_zero ? DONE : CALC;
          end
        end
        CALC: begin
          if (abort)              state_q <= IDLE;
          else if (cnt_q == '0)   state_q <= DONE;
          else                    cnt_q   <= cnt_q - CW'(1);
        end
        DONE: begin
          // IDLE is entered first, so no new operation is taken on this edge
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/robs_mult_seq.sv
// Sequential Robertson's multiplier, one multiplier bit per cycle.
// Signed (two's complement) or unsigned operands selected per operation.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready = IDLE)
//   multiplicand          : Y operand, WIDTH bits
//   multiplier            : X operand, WIDTH bits
//   is_signed             : 1 = two's complement, 0 = unsigned
//   abort                 : cancel an in-flight operation (CALC only)
//   out_valid / out_ready : product handshake (out_valid = DONE)
//   product               : {A, X}, 2*WIDTH bits
//   zero_flag             : product == 0 while out_valid
//   busy                  : iteration in progress
module robs_mult_seq
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 is_signed,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 zero_flag,
  output logic                 busy
);

  localparam int CW = robs_cw(WIDTH);

  logic load, step, last_step, op_zero;

  logic [WIDTH-1:0] a_q, x_q, y_q;
  logic             sgn_q;

  logic [WIDTH-1:0]      addend;
  logic signed [WIDTH:0] ext_a, ext_y, sum;

  assign op_zero = (multiplicand == '0) || (multiplier == '0);

  robs_mult_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op_zero   (op_zero),
    .abort     (abort),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .load      (load),
    .step      (step),
    .last_step (last_step)
  );

  // A +/- Y in WIDTH+1 bits. Extending by the sign (signed) or by zero
  // (unsigned) makes sum[WIDTH] the correct bit to shift into A: the carry
  // for unsigned, the sign of the partial product for signed. That is the
  // sticky sign-fill flag, and it also stays correct on the subtract step
  // (e.g. 0 - (-2^(W-1)) is positive).
  always_comb begin
    addend = x_q[0] ? y_q : '0;
    ext_a  = $signed({sgn_q & a_q[WIDTH-1], a_q});
    ext_y  = $signed({sgn_q & addend[WIDTH-1], addend});
    // The multiplier's MSB carries weight -2^(W-1) in signed mode.
    sum    = (sgn_q && last_step) ? (ext_a - ext_y) : (ext_a + ext_y);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      sgn_q <= 1'b0;
    end else if (load) begin
      y_q   <= multiplicand;
      sgn_q <= is_signed;
      a_q   <= '0;
      // A zero operand skips the iterations, so the product is already {0,0}.
      x_q   <= op_zero ? '0 : multiplier;
    end else if (step) begin
      a_q   <= sum[WIDTH:1];
      x_q   <= {sum[0], x_q[WIDTH-1:1]};
    end
  end

  assign product   = {a_q, x_q};
  assign zero_flag = out_valid && (product == '0);

endmodule

// File: tb/tb_robs_mult_seq.sv
module tb_robs_mult_seq;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           is_signed;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           zero_flag;
  logic           busy;

  int passed;
  int total;

  robs_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .is_signed    (is_signed),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .zero_flag    (zero_flag),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer multiplication of the operands as interpreted.
  function automatic logic [15:0] ref_mul(input logic [7:0] y, input logic [7:0] x,
                                          input logic s);
    longint r;
    if (s) r = longint'($signed(y)) * longint'($signed(x));
    else   r = longint'(y) * longint'(x);
    return 16'(r);
  endfunction

  function automatic int ref_lat(input logic [7:0] y, input logic [7:0] x);
    return (y == 8'd0 || x == 8'd0) ? 0 : W;
  endfunction

  // Offers one operation, waits for out_valid (bounded) and, if out_ready
  // is high, consumes it. Called and returns at 1 time unit after a posedge.
  // lat = number of clock edges after the accept edge until out_valid.
  task automatic run_op(input logic [7:0] y, input logic [7:0] x, input logic s,
                        output logic [15:0] p, output logic zf, output int lat,
                        output bit to);
    int n;
    multiplicand = y;
    multiplier   = x;
    is_signed    = s;
    in_valid     = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid     = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    is_signed    = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    to = !out_valid;
    p  = product;
    zf = zero_flag;
    if (out_ready && !to) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
    total++; if (product !== 16'h0000) $display("FAIL reset_product got %h exp 0000", product); else passed++;
    total++; if (zero_flag !== 1'b0) $display("FAIL reset_zero_flag got %b exp 0", zero_flag); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
  endtask

  task automatic test_signed_basic();
    logic [15:0] p; logic zf; int lat; bit to;
    run_op(8'hFD, 8'h05, 1'b1, p, zf, lat, to);
    total++; if (to) $display("FAIL m3x5_timeout out_valid not seen in 40 cycles"); else passed++;
    total++; if (p !== 16'hFFF1) $display("FAIL m3x5_product got %h exp fff1", p); else passed++;
    total++; if (lat !== W) $display("FAIL m3x5_latency got %0d exp %0d", lat, W); else passed++;
    total++; if (zf !== 1'b0) $display("FAIL m3x5_zero_flag got %b exp 0", zf); else passed++;
  endtask

  task automatic test_corners();
    logic [15:0] p; logic zf; int lat; bit to;
    logic [7:0] ys [4] = '{8'h80, 8'h7F, 8'hFF, 8'hFF};
    logic [7:0] xs [4] = '{8'h80, 8'h80, 8'hFF, 8'hFF};
    logic       ss [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] ex [4] = '{16'h4000, 16'hC080, 16'hFE01, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      run_op(ys[i], xs[i], ss[i], p, zf, lat, to);
      total++;
      if (to || p !== ex[i])
        $display("FAIL corner_%0d product got %h (timeout=%0b) exp %h", i, p, to, ex[i]);
      else passed++;
    end
  endtask

  task automatic test_zero_exit();
    logic [15:0] p; logic zf; int lat; bit to;
    run_op(8'h00, 8'h7F, 1'b1, p, zf, lat, to);
    total++; if (to) $display("FAIL zero_exit_timeout out_valid not seen"); else passed++;
    total++; if (lat !== 0) $display("FAIL zero_exit_latency got %0d extra edges exp 0", lat); else passed++;
    total++; if (p !== 16'h0000) $display("FAIL zero_exit_product got %h exp 0000", p); else passed++;
    total++; if (zf !== 1'b1) $display("FAIL zero_exit_zero_flag got %b exp 1", zf); else passed++;
    run_op(8'h93, 8'h00, 1'b0, p, zf, lat, to);
    total++; if (to || lat !== 0 || p !== 16'h0000 || zf !== 1'b1)
      $display("FAIL zero_mult_exit got p=%h lat=%0d zf=%b exp p=0000 lat=0 zf=1", p, lat, zf);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [15:0] p; logic zf; int lat; bit to;
    out_ready = 1'b0;
    run_op(8'h03, 8'h04, 1'b0, p, zf, lat, to);
    total++; if (to || p !== 16'h000C) $display("FAIL bp_product got %h exp 000c", p); else passed++;
    // New offer and abort while held in DONE must both be ignored.
    multiplicand = 8'h09; multiplier = 8'h09; is_signed = 1'b0;
    in_valid = 1'b1; abort = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (product !== 16'h000C || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d got p=%h ov=%b ir=%b exp p=000c ov=1 ir=0",
                 i, product, out_valid, in_ready);
      else passed++;
    end
    abort = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    else passed++;
    total++; if (busy !== 1'b0) $display("FAIL bp_no_same_cycle_accept busy got %b exp 0", busy); else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] p; logic zf; int lat; bit to;
    bit seen;
    // abort while cnt==3
    multiplicand = 8'h25; multiplier = 8'h31; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) $display("FAIL abort3_busy_before got %b exp 1", busy); else passed++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL abort3_idle got ir=%b busy=%b ov=%b exp 1 0 0", in_ready, busy, out_valid);
    else passed++;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen |= out_valid; end
    total++; if (seen !== 1'b0) $display("FAIL abort3_no_out_valid got %b exp 0", seen); else passed++;
    // abort on the final iteration (cnt==0)
    multiplicand = 8'h11; multiplier = 8'h13; is_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL abort0_wins got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    else passed++;
    run_op(8'h0B, 8'hF5, 1'b1, p, zf, lat, to);
    total++; if (to || p !== ref_mul(8'h0B, 8'hF5, 1'b1))
      $display("FAIL abort_followup got %h exp %h", p, ref_mul(8'h0B, 8'hF5, 1'b1));
    else passed++;
  endtask

  task automatic test_reset_midcalc();
    logic [15:0] p; logic zf; int lat; bit to;
    multiplicand = 8'h7B; multiplier = 8'h6D; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    total++; if (product !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL async_reset got p=%h ov=%b ir=%b busy=%b exp 0000 0 1 0",
               product, out_valid, in_ready, busy);
    else passed++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    run_op(8'd6, 8'd7, 1'b1, p, zf, lat, to);
    total++; if (to || p !== 16'h002A || lat !== W)
      $display("FAIL after_reset_6x7 got p=%h lat=%0d exp 002a lat=%0d", p, lat, W);
    else passed++;
  endtask

  task automatic test_random(input int n);
    logic [15:0] p; logic zf; int lat; bit to;
    logic [7:0] y, x; logic s; logic [15:0] e;
    int hold;
    for (int i = 0; i < n; i++) begin
      y = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      x = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 7) == 0) y = 8'h80;
      s = 1'($urandom);
      e = ref_mul(y, x, s);
      out_ready = ($urandom_range(0, 3) != 0);
      run_op(y, x, s, p, zf, lat, to);
      total++; if (to || p !== e)
        $display("FAIL rand_%0d product y=%h x=%h s=%b got %h exp %h", i, y, x, s, p, e);
      else passed++;
      total++; if (zf !== (e == 16'h0000))
        $display("FAIL rand_%0d zero_flag got %b exp %b", i, zf, (e == 16'h0000));
      else passed++;
      total++; if (lat !== ref_lat(y, x))
        $display("FAIL rand_%0d latency got %0d exp %0d", i, lat, ref_lat(y, x));
      else passed++;
      if (!out_ready && !to) begin
        hold = $urandom_range(1, 3);
        repeat (hold) begin @(posedge clk); #1; end
        total++; if (product !== e || out_valid !== 1'b1)
          $display("FAIL rand_%0d held got p=%h ov=%b exp %h 1", i, product, out_valid, e);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    is_signed = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    #12;
    test_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    test_signed_basic();
    test_corners();
    test_zero_exit();
    test_backpressure();
    test_abort();
    test_reset_midcalc();
    test_random(3000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
